// File: rtl/img_stream_pkg.sv
// Shared definitions for the length-prefixed image word stream.
package img_stream_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    FILL,
    SEND_HDR,
    SEND_DATA
  } pack_state_t;

  // Number of payload words needed to carry n bytes.
  function automatic int unsigned words_for_bytes(input int unsigned n);
    return (n + 32'd3) >> 2;
  endfunction

endpackage

// File: rtl/packer_ram.sv
// Single-port frame buffer: synchronous write, registered read (old data on read-during-write).
module packer_ram #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem_q [2**ADDR_BITS];
  logic [WIDTH-1:0] rdata_q;

  // Write port and registered read share one address.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_packer.sv
// Packs a byte stream into 32-bit words, buffers the frame, then sends a
// byte-count header followed by the payload words back-to-back.
module frame_packer
  import img_stream_pkg::*;
#(
  parameter int POW2_N = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              upstream_stall,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              downstream_stall,
  output logic              overflow
);

  localparam int CNT_W     = POW2_N + 3;
  localparam int MAX_BYTES = BYTES_PER_WORD * (2 ** POW2_N);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  pack_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] pack_q, pack_d;
  logic [POW2_N-1:0] rd_idx_q, rd_idx_d;
  logic              overflow_q, overflow_d;

  logic              in_fire;
  logic              out_fire;
  logic              hit_max;
  logic              byte_is_last;
  logic              last_word;
  logic [CNT_W-1:0]  cnt_inc;
  logic [1:0]        lane;
  logic [WORD_W-1:0] merged;
  logic [POW2_N-1:0] last_idx;

  logic              ram_we;
  logic [POW2_N-1:0] ram_addr;
  logic [WORD_W-1:0] ram_rdata;

  assign in_fire      = in_valid && (state_q == FILL);
  assign out_fire     = out_valid && !downstream_stall;
  assign cnt_inc      = cnt_q + CNT_W'(1);
  assign hit_max      = (cnt_inc == MAX_CNT);
  assign byte_is_last = in_last || hit_max;
  assign lane         = cnt_q[1:0];
  assign last_idx     = POW2_N'(words_for_bytes(32'(cnt_q)) - 32'd1);
  assign last_word    = (rd_idx_q == last_idx);

  // Byte lanes: below the incoming lane keep packed bytes, the lane itself
  // takes the new byte, lanes above are zero so a short final word is padded.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    assign merged[8*gi +: 8] = (lane == 2'(gi)) ? in_byte :
                               (lane >  2'(gi)) ? pack_q[8*gi +: 8] : 8'h00;
  end

  packer_ram #(
    .WIDTH    (WORD_W),
    .ADDR_BITS(POW2_N)
  ) u_ram (
    .clock(clock),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(merged),
    .rdata(ram_rdata)
  );

  // State and datapath registers; reset discards any frame in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      pack_q     <= '0;
      rd_idx_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pack_q     <= pack_d;
      rd_idx_q   <= rd_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // Next-state: a closing byte starts the send, the last accepted word ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (in_fire && byte_is_last) begin
          state_d = SEND_HDR;
        end
      end
      SEND_HDR: begin
        if (out_fire) begin
          state_d = SEND_DATA;
        end
      end
      SEND_DATA: begin
        if (out_fire && last_word) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Datapath: packing and RAM writes while filling, read-address prefetch while sending.
  always_comb begin
    cnt_d      = cnt_q;
    pack_d     = pack_q;
    rd_idx_d   = rd_idx_q;
    overflow_d = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = cnt_q[POW2_N+1:2];
    case (state_q)
      FILL: begin
        if (in_fire) begin
          cnt_d      = cnt_inc;
          pack_d     = merged;
          ram_we     = (lane == 2'd3) || byte_is_last;
          overflow_d = hit_max && !in_last;
        end
      end
      SEND_HDR: begin
        // Word 0 is fetched while the header is on the bus.
        ram_addr = '0;
        rd_idx_d = '0;
      end
      SEND_DATA: begin
        // Holding the address under stall keeps the read data stable.
        if (out_fire) begin
          rd_idx_d = rd_idx_q + POW2_N'(1);
          ram_addr = rd_idx_q + POW2_N'(1);
          if (last_word) begin
            cnt_d  = '0;
            pack_d = '0;
          end
        end else begin
          ram_addr = rd_idx_q;
        end
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Outputs decoded from state: header carries the byte count, data comes from RAM.
  always_comb begin
    upstream_stall = 1'b0;
    out_valid      = 1'b0;
    out_data       = '0;
    case (state_q)
      SEND_HDR: begin
        upstream_stall = 1'b1;
        out_valid      = 1'b1;
        out_data       = WORD_W'(cnt_q);
      end
      SEND_DATA: begin
        upstream_stall = 1'b1;
        out_valid      = 1'b1;
        out_data       = ram_rdata;
      end
      default: begin
        upstream_stall = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;
      end
    endcase
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_frame_packer.sv
// Scoreboard bench for frame_packer (small RAM so overflow is reachable).
module tb_frame_packer;

  localparam int POW2_N = 2;
  localparam int MAX_B  = 4 * (2 ** POW2_N);

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        upstream_stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic        downstream_stall = 1'b0;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  int ds_mode = 0;  // 0 = never stall, 1 = always stall, 2 = random

  typedef struct {
    logic [31:0] data;
    bit          eof;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] cur_q[$];

  frame_packer #(.POW2_N(POW2_N)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_byte         (in_byte),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .upstream_stall  (upstream_stall),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .downstream_stall(downstream_stall),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // Turn the bytes collected for the current frame into expected words.
  task automatic push_frame();
    int n;
    int nw;
    logic [31:0] w;
    exp_t e;
    n  = cur_q.size();
    nw = (n + 3) / 4;
    e.data = 32'(n);
    e.eof  = 1'b0;
    exp_q.push_back(e);
    for (int wi = 0; wi < nw; wi++) begin
      w = '0;
      for (int bi = 0; bi < 4; bi++) begin
        if (wi * 4 + bi < n) w[8*bi +: 8] = cur_q[wi*4 + bi];
      end
      e.data = w;
      e.eof  = (wi == nw - 1);
      exp_q.push_back(e);
    end
    cur_q.delete();
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit last);
    int guard;
    bit hit;
    bit done;
    guard    = 0;
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = last;
    @(negedge clock);
    while (upstream_stall && guard < 500) begin
      guard++;
      @(negedge clock);
    end
    if (upstream_stall) check("accept_wait", {31'd0, upstream_stall}, 32'd0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    cur_q.push_back(b);
    hit  = (cur_q.size() == MAX_B);
    done = last || hit;
    check("overflow", {31'd0, overflow}, {31'd0, hit && !last});
    check("stall_after_byte", {31'd0, upstream_stall}, {31'd0, done});
    check("valid_after_byte", {31'd0, out_valid}, {31'd0, done});
    if (done) begin
      check("header_now", out_data, 32'(cur_q.size()));
      push_frame();
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(posedge clock);
      guard++;
    end
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Downstream back-pressure generator.
  initial forever begin
    @(posedge clock);
    #2;
    case (ds_mode)
      0:       downstream_stall = 1'b0;
      1:       downstream_stall = 1'b1;
      default: downstream_stall = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: pops the scoreboard on each consumed word.
  initial begin
    logic [31:0] prev_data;
    bit prev_hold;
    bit prev_mid;
    bit prev_end;
    exp_t e;
    prev_data = '0;
    prev_hold = 0;
    prev_mid  = 0;
    prev_end  = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_hold = 0;
        prev_mid  = 0;
        prev_end  = 0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", {31'd0, out_valid}, 32'd1);
          check("hold_data", out_data, prev_data);
        end
        if (prev_mid) check("no_bubble", {31'd0, out_valid}, 32'd1);
        if (prev_end) begin
          check("end_valid", {31'd0, out_valid}, 32'd0);
          check("end_stall", {31'd0, upstream_stall}, 32'd0);
        end
        prev_hold = out_valid && downstream_stall;
        prev_data = out_data;
        prev_mid  = 0;
        prev_end  = 0;
        if (out_valid && !downstream_stall) begin
          if (exp_q.size() == 0) begin
            check("extra_word", {31'd0, out_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            $display("word %08h expected %08h eof=%0d", out_data, e.data, e.eof);
            check("word", out_data, e.data);
            prev_mid = !e.eof;
            prev_end = e.eof;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_stall", {31'd0, upstream_stall}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    @(posedge clock);
    #1;

    // Five bytes, padded final word.
    for (int i = 1; i <= 5; i++) drive_byte(8'(i), i == 5);
    // Exactly one word, immediately followed by a single-byte frame.
    for (int i = 1; i <= 4; i++) drive_byte(8'(i * 17), i == 4);
    drive_byte(8'hAA, 1'b1);
    wait_drain();

    // Nine random bytes under random back-pressure.
    ds_mode = 2;
    for (int i = 0; i < 9; i++) drive_byte(8'($urandom_range(0, 255)), i == 8);
    wait_drain();
    ds_mode = 0;
    @(posedge clock);
    #1;

    // Full frame closed by in_last exactly at capacity: no overflow.
    for (int i = 0; i < MAX_B; i++) drive_byte(8'(8'h40 + i), i == MAX_B - 1);
    // Capacity reached without in_last, then byte 17 opens the next frame.
    for (int i = 0; i < MAX_B + 1; i++) drive_byte(8'(8'h80 + i), 1'b0);
    drive_byte(8'hC3, 1'b1);
    wait_drain();

    // Reset while payload words are being sent.
    ds_mode = 1;
    for (int i = 0; i < 9; i++) drive_byte(8'(8'hE0 + i), i == 8);
    repeat (2) @(posedge clock);
    #1;
    ds_mode = 0;
    repeat (2) @(posedge clock);
    #1;
    ds_mode = 1;
    reset = 1'b1;
    exp_q.delete();
    cur_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midsend_rst_valid", {31'd0, out_valid}, 32'd0);
    check("midsend_rst_stall", {31'd0, upstream_stall}, 32'd0);
    ds_mode = 0;
    drive_byte(8'h5A, 1'b0);
    drive_byte(8'hA5, 1'b1);
    wait_drain();

    repeat (3) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
